// File: rtl/prio_encoder_q_if.sv
`default_nettype none
// ============================================================================
// Module   : prio_encoder_q_if
// Purpose  : Request/issue bundle for prio_encoder_q. It carries the request
//            load path, the valid/ready issue handshake, the cascade enables
//            and the pending-set view.
// Ports    : master - request source and consumer side (drives ein, load,
//                     req_in and ready; observes y, valid, gs, eout, pending)
//            slave  - encoder side (the mirror of master)
// Revision : 1.0 - initial release
// ============================================================================
interface prio_encoder_q_if #(
  parameter int N = 8
);
  localparam int IDX_W = $clog2(N);

  logic             ein;
  logic             load;
  logic [N-1:0]     req_in;
  logic             ready;
  logic [IDX_W-1:0] y;
  logic             valid;
  logic             gs;
  logic             eout;
  logic [N-1:0]     pending;

  modport master (
    output ein, load, req_in, ready,
    input  y, valid, gs, eout, pending
  );

  modport slave (
    input  ein, load, req_in, ready,
    output y, valid, gs, eout, pending
  );
endinterface
`default_nettype wire

// File: rtl/prio_encoder_q.sv
`default_nettype none
// ============================================================================
// Module   : prio_encoder_q
// Purpose  : Registered, queued priority encoder. Request lines are OR-merged
//            into a pending set. One encoded index is then issued per
//            valid/ready transfer, highest index first. The ein/gs/eout
//            cascade is kept, so several instances can be chained.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - prio_encoder_q_if.slave (ein, load, req_in, ready in;
//                    y, valid, gs, eout, pending out)
// Options  : ROUND_ROBIN_EN - when defined, selection searches downward from
//            a rotating pointer with wrap, instead of fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module prio_encoder_q #(
  parameter int N = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  prio_encoder_q_if.slave    bus
);
  localparam int IDX_W = $clog2(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_pending;
  logic [IDX_W-1:0] r_y;
  logic             r_valid;

  logic [IDX_W-1:0] w_sel;
  logic             w_any;
  logic             w_issue;
  logic [N-1:0]     w_issue_mask;

  // Highest set index of a vector. Returns 0 for an all-zero vector; callers
  // only use the result when the vector is non-zero.
  function automatic logic [IDX_W-1:0] f_highest(input logic [N-1:0] v);
    logic [IDX_W-1:0] hi;
    hi = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) hi = IDX_W'(i);
    end
    return hi;
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     w_lo_mask;
  logic [N-1:0]     w_lo_pending;

  // A wrapped downward search from ptr is the same as two searches. Take the
  // highest pending bit at or below ptr first. When there is none, the search
  // wraps, so take the highest pending bit overall.
  always_comb begin
    w_lo_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_lo_mask[i] = (i <= int'(r_ptr));
    end
  end

  assign w_lo_pending = r_pending & w_lo_mask;
  assign w_sel        = (|w_lo_pending) ? f_highest(w_lo_pending)
                                        : f_highest(r_pending);
`else
  assign w_sel = f_highest(r_pending);
`endif

  assign w_any = |r_pending;

  // An issue needs ein and a non-empty pending set. The output register must
  // also be free: it is either idle or being consumed this cycle.
  assign w_issue = bus.ein && w_any && ((r_state == IDLE) || bus.ready);

  assign w_issue_mask = w_issue ? ({{(N-1){1'b0}}, 1'b1} << w_sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_y       <= '0;
      r_valid   <= 1'b0;
`ifdef ROUND_ROBIN_EN
      r_ptr     <= IDX_W'(N - 1);
`endif
    end else begin
      // The clear is applied before the merge. A request that is re-asserted
      // on the same edge its bit is issued therefore stays pending.
      r_pending <= (r_pending & ~w_issue_mask) | (bus.load ? bus.req_in : '0);

      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
            r_y     <= w_sel;
          end
        end
        HOLD: begin
          // With ready low, y and valid are held whatever ein does.
          if (bus.ready) begin
            if (w_issue) begin
              r_y <= w_sel;
            end else begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase

`ifdef ROUND_ROBIN_EN
      if (w_issue) begin
        r_ptr <= (w_sel == '0) ? IDX_W'(N - 1) : (w_sel - 1'b1);
      end
`endif
    end
  end

  assign bus.y       = r_y;
  assign bus.valid   = r_valid;
  assign bus.gs      = r_valid;
  assign bus.pending = r_pending;
  // eout comes only from registers and ein. It is forced low while reset is
  // asserted.
  assign bus.eout    = rst_n & bus.ein & ~r_valid & ~w_any;

endmodule
`default_nettype wire
